// File: rtl/eth_fcs_crc32.sv
// rtl/eth_fcs_crc32.sv - byte-serial Ethernet FCS (CRC-32) engine; optional CRC32_CHECK_EN adds o_crc_ok residue check
module eth_fcs_crc32 #(
    parameter logic [31:0] POLY = 32'hEDB88320,
    parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_calc,
    input  logic        i_vl,
    input  logic [7:0]  i_data,
`ifdef CRC32_CHECK_EN
    output logic        o_crc_ok,
`endif
    output logic [31:0] o_crc32
);

    logic [31:0] c;

    // Eight LSB-first shift steps unrolled into one combinational XOR tree.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] t;
        t = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            t = t[0] ? ((t >> 1) ^ POLY) : (t >> 1);
        end
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= INIT;
        end else if (!i_vl) begin
            c <= INIT;
        end else if (i_calc) begin
            c <= crc_byte(c, i_data);
        end else begin
            // Filling with ones leaves c at INIT once all four FCS bytes are out.
            c <= {8'hFF, c[31:8]};
        end
    end

    assign o_crc32 = ~c;

`ifdef CRC32_CHECK_EN
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_crc_ok <= 1'b0;
        end else begin
            o_crc_ok <= (c == RESIDUE);
        end
    end
`endif

endmodule

// File: tb/tb_eth_fcs_crc32.sv
// tb/tb_eth_fcs_crc32.sv - randomized self-checking bench for eth_fcs_crc32 against a table-driven CRC model
module tb_eth_fcs_crc32;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_calc;
    logic        i_vl;
    logic [7:0]  i_data;
    logic [31:0] o_crc32;
`ifdef CRC32_CHECK_EN
    logic        o_crc_ok;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] crc_tab [256];
    logic [31:0] mc;
    logic [7:0]  check_str [9];
    logic [7:0]  frame [$];

    always #5 clk = ~clk;

    eth_fcs_crc32 dut (
        .clk     (clk),
        .rst     (rst),
        .i_calc  (i_calc),
        .i_vl    (i_vl),
        .i_data  (i_data),
`ifdef CRC32_CHECK_EN
        .o_crc_ok(o_crc_ok),
`endif
        .o_crc32 (o_crc32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-at-a-time table lookup on the running CRC, shift phase emits ~crc LSB byte first.
    task automatic drive(input logic vl, input logic calc, input logic [7:0] d, input string tag);
        i_vl = vl; i_calc = calc; i_data = d;
        @(posedge clk);
        #1;
        if (!vl)       mc = 32'hFFFFFFFF;
        else if (calc) mc = crc_tab[(mc ^ {24'h0, d}) & 32'hFF] ^ (mc >> 8);
        else           mc = {8'hFF, mc[31:8]};
        check(tag, o_crc32, ~mc);
    endtask

    task automatic send_check_str(input string tag);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, check_str[i], tag);
        check({tag, "_crc"}, o_crc32, 32'hCBF43926);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] fcs;
        int len;
        for (int n = 0; n < 256; n++) begin
            r = n;
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            crc_tab[n] = r;
        end
        for (int i = 0; i < 9; i++) check_str[i] = 8'h31 + 8'(i);

        // Reset dominates active inputs.
        rst = 1'b1; i_vl = 1'b1; i_calc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'($urandom);
            @(posedge clk);
        end
        #1;
        check("reset", o_crc32, 32'h0);
        rst = 1'b0;
        mc = 32'hFFFFFFFF;
        drive(1'b0, 1'b0, 8'h00, "idle");

        // Check string and FCS shift-out.
        send_check_str("chk");
        drive(1'b1, 1'b0, 8'h00, "sh0"); check("fcs0", {24'h0, o_crc32[7:0]}, 32'h39);
        drive(1'b1, 1'b0, 8'h00, "sh1"); check("fcs1", {24'h0, o_crc32[7:0]}, 32'hF4);
        drive(1'b1, 1'b0, 8'h00, "sh2"); check("fcs2", {24'h0, o_crc32[7:0]}, 32'hCB);
        drive(1'b1, 1'b0, 8'h00, "sh3"); check("fcs_done", o_crc32, 32'h0);

        // Preamble and SFD do not disturb the CRC.
        drive(1'b0, 1'b0, 8'h00, "gap");
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, "pre");
        drive(1'b1, 1'b0, 8'hD5, "sfd");
        send_check_str("pre_chk");

        // Re-arm by dropping i_vl for one cycle.
        drive(1'b0, 1'b1, 8'hAA, "rearm");
        check("rearm_zero", o_crc32, 32'h0);
        send_check_str("rearm_chk");

        // Minimum frame: 60 bytes 00..3B, FCS bytes against the reference.
        drive(1'b0, 1'b0, 8'h00, "gap2");
        frame.delete();
        for (int i = 0; i < 60; i++) begin
            frame.push_back(8'(i));
            drive(1'b1, 1'b1, 8'(i), "min");
        end
        fcs = ~mc;
        for (int i = 0; i < 4; i++) begin
            check("min_fcs_byte", {24'h0, o_crc32[7:0]}, {24'h0, fcs[8*i +: 8]});
            drive(1'b1, 1'b0, 8'h00, "min_sh");
        end
        check("min_sh_done", o_crc32, 32'h0);

        // Frame plus its own FCS leaves the fixed residue.
        drive(1'b0, 1'b0, 8'h00, "gap3");
        for (int i = 0; i < 60; i++) drive(1'b1, 1'b1, frame[i], "res");
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, fcs[8*i +: 8], "res_fcs");
        check("residue", o_crc32, 32'h2144DF1C);
        drive(1'b0, 1'b0, 8'h00, "res_end");
`ifdef CRC32_CHECK_EN
        check("crc_ok", {31'h0, o_crc_ok}, 32'h1);
        drive(1'b0, 1'b0, 8'h00, "ok_clr");
        check("crc_ok_clr", {31'h0, o_crc_ok}, 32'h0);
`endif

        // Abort mid-frame, then a clean frame.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'($urandom), "abort_bytes");
        drive(1'b0, 1'b1, 8'($urandom), "abort");
        check("abort_zero", o_crc32, 32'h0);
        send_check_str("abort_chk");

        // Randomized frames with random lengths, preamble and FCS shift-out.
        for (int f = 0; f < 20; f++) begin
            drive(1'b0, 1'b0, 8'h00, "rnd_gap");
            for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, (i == 7) ? 8'hD5 : 8'h55, "rnd_pre");
            len = $urandom_range(1, 80);
            for (int i = 0; i < len; i++) drive(1'b1, 1'b1, 8'($urandom), "rnd_data");
            for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'($urandom), "rnd_shift");
            check("rnd_shift_done", o_crc32, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
